bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width, and the digit-count sizing helper
// used by the elaboration-time parameter check.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest digit count d with 10**d >= 2**bin_w, i.e. enough digits for
  // every unsigned value of a bin_w-bit word.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned lim;
    longint unsigned pw;
    int unsigned     d;
    lim = 64'd1 << bin_w;
    pw  = 64'd1;
    d   = 0;
    while (pw < lim) begin
      pw = pw * 64'd10;
      d  = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   d    - current BCD digit
//   q_c  - corrected digit (combinational)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q_c
);

  assign q_c = (d >= DIGIT_W'(5)) ? DIGIT_W'(d + DIGIT_W'(3)) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock,
// with optional two's-complement input and valid/ready on both sides.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - input handshake (in_ready high only in IDLE)
//   bin_in, signed_in     - operand and its signedness
//   out_valid / out_ready - output handshake, result held until accepted
//   bcd_out               - packed BCD magnitude, digit 0 in [3:0]
//   sign_out              - result is negative
//   ndigits               - significant digit count, 1..DIGITS
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_W-1:0]               bin_in,
  input  logic                           signed_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIGIT_W*DIGITS-1:0]      bcd_out,
  output logic                           sign_out,
  output logic [$clog2(DIGITS+1)-1:0]    ndigits
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned ND_W  = $clog2(DIGITS + 1);

  // Parameter legality, checked at elaboration.
  if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be in 2..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj_c;
  logic [SR_W-1:0]  sr_next_c;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_c;
  logic [BIN_W-1:0] mag_c;
  logic [ND_W-1:0]  nd_c;

  // Operand sign and magnitude; the most negative value maps to 2**(BIN_W-1).
  assign sign_c = signed_in & bin_in[BIN_W-1];
  assign mag_c  = sign_c ? BIN_W'(~bin_in + BIN_W'(1)) : bin_in;

  // All BCD digits corrected in parallel, binary part passes through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d   (sr[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .q_c (sr_adj_c[BIN_W + DIGIT_W*g +: DIGIT_W])
    );
  end
  assign sr_adj_c[BIN_W-1:0] = sr[BIN_W-1:0];

  assign sr_next_c = sr_adj_c << 1;

  // Significant digits of the value the current step produces.
  always_comb begin
    nd_c = ND_W'(1);
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (sr_next_c[BIN_W + DIGIT_W*i +: DIGIT_W] != '0) nd_c = ND_W'(i + 1);
    end
  end

  // Control FSM with datapath registers; outputs only update on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      sign_out  <= 1'b0;
      ndigits   <= ND_W'(1);
      cnt       <= '0;
      sr        <= '0;
      sign_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q   <= sign_c;
            sr       <= {BCD_W'(0), mag_c};
            cnt      <= CNT_W'(BIN_W);
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_next_c;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_out   <= sr_next_c[SR_W-1 -: BCD_W];
            sign_out  <= sign_q;
            ndigits   <= nd_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default 12-bit/4-digit instance driven
// through a scoreboard, plus a 16-bit/5-digit instance for the wide case.
module tb_bin2bcd_seq;

  typedef struct {
    logic [31:0] bcd;
    logic        sign;
    logic [31:0] nd;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] bin_in = '0;
  logic        signed_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] bcd_out;
  logic        sign_out;
  logic [2:0]  ndigits;

  logic        v16 = 1'b0;
  logic        r16;
  logic [15:0] b16 = '0;
  logic        s16 = 1'b0;
  logic        ov16;
  logic [19:0] bcd16;
  logic        sg16;
  logic [2:0]  nd16;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_acc = 0;
  int rise_cyc = 0;
  bit ov_prev  = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .signed_in(signed_in), .out_valid(out_valid),
    .out_ready(out_ready), .bcd_out(bcd_out), .sign_out(sign_out),
    .ndigits(ndigits)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .bin_in(b16), .signed_in(s16), .out_valid(ov16),
    .out_ready(1'b1), .bcd_out(bcd16), .sign_out(sg16),
    .ndigits(nd16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference result by repeated division, independent of the shift-add method.
  function automatic exp_t model(input int unsigned b, input bit s, input int w);
    exp_t e;
    int unsigned mag;
    int unsigned dig;
    e.sign = s && b[w-1];
    mag    = e.sign ? ((32'd1 << w) - b) : b;
    e.bcd  = '0;
    e.nd   = 1;
    e.acc  = 0;
    for (int i = 0; i < 5; i++) begin
      dig = mag % 10;
      e.bcd = e.bcd | (dig << (4 * i));
      if (dig != 0) e.nd = i + 1;
      mag = mag / 10;
    end
    return e;
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) last_acc = cyc + 1;
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("bcd_out", 32'(bcd_out), e.bcd);
          chk("sign_out", 32'(sign_out), 32'(e.sign));
          chk("ndigits", 32'(ndigits), e.nd);
          chk("latency", 32'(rise_cyc - e.acc), 32'd12);
        end
      end
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic send(input logic [11:0] b, input bit s, input bit hold);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    bin_in    = b;
    signed_in = s;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    e = model(32'(b), s, 12);
    e.acc = last_acc;
    exp_q.push_back(e);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    logic [15:0] w16 [2];
    logic        ws16 [2];
    logic [19:0] we16 [2];
    logic        wsg16 [2];
    logic [2:0]  wnd16 [2];

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd_out", 32'(bcd_out), 32'd0);
    chk("rst_ndigits", 32'(ndigits), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    send(12'd4095, 1'b0, 1'b0);
    send(12'd0, 1'b0, 1'b0);
    send(12'd7, 1'b0, 1'b0);
    send(12'd10, 1'b0, 1'b0);
    send(12'h800, 1'b1, 1'b0);
    send(12'hFFF, 1'b1, 1'b0);
    send(12'h800, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      send(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Back-pressure with a second word waiting on the input.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(12'd1234, 1'b0, 1'b1);
    bin_in = 12'd567;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_bcd_hold", 32'(bcd_out), 32'h1234);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(12'd567, 1'b0, 1'b0);
    drain();

    // Reset in the middle of a conversion.
    send(12'd4095, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bcd_out", 32'(bcd_out), 32'd0);
    chk("mid_rst_sign_out", 32'(sign_out), 32'd0);
    chk("mid_rst_ndigits", 32'(ndigits), 32'd1);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    send(12'd999, 1'b0, 1'b0);
    drain();

    // Wide instance: 16-bit input, 5 digits.
    w16[0] = 16'hFFFF; ws16[0] = 1'b0; we16[0] = 20'h65535; wsg16[0] = 1'b0; wnd16[0] = 3'd5;
    w16[1] = 16'h8000; ws16[1] = 1'b1; we16[1] = 20'h32768; wsg16[1] = 1'b1; wnd16[1] = 3'd5;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      t = 0;
      while (!r16 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      v16 = 1'b1; b16 = w16[k]; s16 = ws16[k];
      @(posedge clk); #1;
      v16 = 1'b0;
      t = 0;
      while (!ov16 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      chk("w16_latency", 32'(t), 32'd16);
      chk("w16_bcd", 32'(bcd16), 32'(we16[k]));
      chk("w16_sign", 32'(sg16), 32'(wsg16[k]));
      chk("w16_nd", 32'(nd16), 32'(wnd16[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
